fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core. It sits directly upstream of decode and immediate generation. It owns the program counter, issues pipelined word reads to instruction memory, and buffers returned words with their PCs in a small in-order queue. It presents instruction/pc to decode over a valid/ready handshake and accepts redirects (branch/jump targets) from execute, flushing all wrong-path state.

---
 rtl/fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage with credit-limited pipelined reads and in-order buffer
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_request,
    output logic [31:0] imem_address,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        instruction_valid,
    input  logic        instruction_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counters hold up to 2*DEPTH (discard can accumulate across back-to-back redirects).
    localparam int CW = $clog2(2 * DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {BOOT, FETCH} state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [CW-1:0] flush_discard;

    logic [PW-1:0] buf_rd;
    logic [PW-1:0] buf_wr;
    logic [PW-1:0] pcq_rd;
    logic [PW-1:0] pcq_wr;

    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc    [DEPTH];
    logic [31:0]   pcq       [DEPTH];

    logic [31:0]   last_instr;
    logic [31:0]   last_pc;

    logic          accept;
    logic          resp_drop;
    logic          resp_keep;
    logic          push;
    logic          pop;

    assign imem_address      = fetch_pc;
    assign accept            = imem_request && imem_ready;
    assign instruction_valid = (count != '0);

    // Responses are matched in order: pending discards are consumed first,
    // a response with nothing in flight is a protocol error and is ignored.
    assign resp_drop = imem_valid && (discard != '0);
    assign resp_keep = imem_valid && (discard == '0) && (outstanding != '0);
    assign push      = resp_keep && !redirect;
    assign pop       = instruction_valid && instruction_ready && !redirect;

    // On redirect every in-flight request becomes a discard; a response landing
    // in the redirect cycle is one of those and is consumed immediately.
    always_comb begin
        flush_discard = discard + outstanding;
        if (imem_valid && (flush_discard != '0)) begin
            flush_discard = flush_discard - CW'(1);
        end
    end

    // Head presentation: show the head entry, otherwise hold the last one shown.
    assign instruction = instruction_valid ? buf_instr[buf_rd] : last_instr;
    assign pc          = instruction_valid ? buf_pc[buf_rd]    : last_pc;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: BOOT lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = FETCH;
            FETCH:   state_next = FETCH;
            default: state_next = BOOT;
        endcase
    end

    // Request issue: only in FETCH, never during a redirect, and only while a
    // buffer slot is reserved for every request in flight.
    always_comb begin
        imem_request = 1'b0;
        if ((state == FETCH) && !redirect && ((outstanding + count) < DEPTH_C)) begin
            imem_request = 1'b1;
        end
    end

    // Control state: fetch PC, in-flight/discard accounting, buffer pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            buf_rd      <= '0;
            buf_wr      <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_target & 32'hFFFF_FFFC;
            discard     <= flush_discard;
            outstanding <= '0;
            count       <= '0;
            buf_rd      <= '0;
            buf_wr      <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
                pcq_wr   <= pcq_wr + PW'(1);
            end
            if (resp_drop) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                buf_wr <= buf_wr + PW'(1);
                pcq_rd <= pcq_rd + PW'(1);
            end
            if (pop) begin
                buf_rd <= buf_rd + PW'(1);
            end
            outstanding <= outstanding + CW'(accept) - CW'(push);
            count       <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage: request PCs in issue order and returned {instruction, pc} pairs.
    always_ff @(posedge clock) begin
        if (!reset && !redirect) begin
            if (accept) begin
                pcq[pcq_wr] <= fetch_pc;
            end
            if (push) begin
                buf_instr[buf_wr] <= imem_data;
                buf_pc[buf_wr]    <= pcq[pcq_rd];
            end
        end
    end

    // Remember the most recent head so outputs hold steady while empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_instr <= 32'h0;
            last_pc    <= 32'h0;
        end else if (instruction_valid) begin
            last_instr <= buf_instr[buf_rd];
            last_pc    <= buf_pc[buf_rd];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a variable-latency memory model
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_request;
    logic [31:0] imem_address;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instruction_valid;
    logic        instruction_ready;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .imem_request      (imem_request),
        .imem_address      (imem_address),
        .imem_ready        (imem_ready),
        .imem_valid        (imem_valid),
        .imem_data         (imem_data),
        .redirect          (redirect),
        .redirect_target   (redirect_target),
        .instruction       (instruction),
        .pc                (pc),
        .instruction_valid (instruction_valid),
        .instruction_ready (instruction_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] expq[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          mem_lat = 1;
    int          n_acc   = 0;
    int          pops    = 0;
    int          extra_pops = 0;
    logic [31:0] last_pop_pc = 32'h0;
    logic [31:0] prev_acc = 32'h0;
    logic        have_prev = 1'b0;
    logic        wrap_seen = 1'b0;
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // One clock cycle, entered and left at the falling edge with inputs already set.
    task automatic step();
        logic        acc;
        logic [31:0] e;
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_data  = word_of(memq[0].addr);
            memq.delete(0);
        end else begin
            imem_valid = 1'b0;
            imem_data  = 32'h0;
        end
        #1;
        s_req   = imem_request;
        s_addr  = imem_address;
        s_valid = instruction_valid;
        acc     = imem_request && imem_ready;
        if (redirect) check_eq("redir_noreq", 32'(imem_request), 32'd0);
        if (instruction_valid && instruction_ready && !redirect) begin
            if (expq.size() == 0) begin
                extra_pops++;
            end else begin
                e = expq.pop_front();
                check_eq("pop_pc", pc, e);
                check_eq("pop_instr", instruction, word_of(e));
                last_pop_pc = pc;
                pops++;
            end
        end
        if (redirect) begin
            expq.delete();
            have_prev = 1'b0;
        end
        if (acc) begin
            if (have_prev && prev_acc == 32'hFFFF_FFFC) begin
                check_eq("wrap_addr", imem_address, 32'h0);
                wrap_seen = 1'b1;
            end
            prev_acc  = imem_address;
            have_prev = 1'b1;
            n_acc++;
            expq.push_back(imem_address);
            memq.push_back('{addr: imem_address, due: cyc + mem_lat});
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redirect        = 1'b1;
        redirect_target = t;
        step();
        redirect        = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        redirect   = 1'b0;
        imem_valid = 1'b0;
        imem_data  = 32'h0;
        @(posedge clock);
        @(negedge clock);
        check_eq("rst_req", 32'(imem_request), 32'd0);
        check_eq("rst_addr", imem_address, RESET_PC);
        check_eq("rst_valid", 32'(instruction_valid), 32'd0);
        check_eq("rst_instr", instruction, 32'h0);
        check_eq("rst_pc", pc, 32'h0);
        expq.delete();
        memq.delete();
        have_prev = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        int first_valid;
        int gaps;
        int p0;
        logic hit;

        reset             = 1'b1;
        redirect          = 1'b0;
        redirect_target   = 32'h0;
        imem_ready        = 1'b1;
        imem_valid        = 1'b0;
        imem_data         = 32'h0;
        instruction_ready = 1'b1;
        @(negedge clock);
        do_reset();

        // Streaming from reset: BOOT cycle, then back-to-back requests.
        first_valid = -1;
        gaps        = 0;
        n_acc       = 0;
        for (int c = 0; c < 24; c++) begin
            step();
            if (c == 0) check_eq("boot_noreq", 32'(s_req), 32'd0);
            if (c == 1) check_eq("first_addr", s_addr, RESET_PC);
            if (s_valid && first_valid < 0) first_valid = c;
            if (first_valid >= 0 && !s_valid) gaps++;
        end
        check_eq("first_valid_cycle", 32'(first_valid), 32'd3);
        check_eq("valid_gaps", 32'(gaps), 32'd0);
        check_eq("accept_count", 32'(n_acc), 32'd23);

        // Decode stall: credits cap requests, then drain without loss.
        instruction_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check_eq("credit_limit", 32'(expq.size() <= DEPTH), 32'd1);
        end
        check_eq("stall_req_drop", 32'(s_req), 32'd0);
        check_eq("stall_valid", 32'(s_valid), 32'd1);
        instruction_ready = 1'b1;
        for (int c = 0; c < 12; c++) step();

        // Redirect with two long-latency responses in flight.
        mem_lat = 3;
        redirect_to(32'h0000_0040);
        step();
        step();
        redirect_to(32'h0000_0103);
        check_eq("redir_valid_clr", 32'(instruction_valid), 32'd0);
        check_eq("redir_addr", imem_address, 32'h0000_0100);
        p0  = pops;
        hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            step();
            if (pops != p0) hit = 1'b1;
        end
        check_eq("redir_first_pop_seen", 32'(hit), 32'd1);
        check_eq("redir_first_pc", last_pop_pc, 32'h0000_0100);
        for (int c = 0; c < 8; c++) step();

        // Memory not ready: address holds until accepted.
        mem_lat    = 1;
        imem_ready = 1'b0;
        redirect_to(32'h0000_0008);
        for (int c = 0; c < 5; c++) begin
            step();
            check_eq("hold_addr", s_addr, 32'h0000_0008);
        end
        imem_ready = 1'b1;
        step();
        check_eq("hold_accept", s_addr, 32'h0000_0008);
        step();
        check_eq("hold_next_addr", s_addr, 32'h0000_000C);
        for (int c = 0; c < 6; c++) step();

        // Redirect coinciding with a response and a pop, buffer nearly full.
        instruction_ready = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (expq.size() == DEPTH && memq.size() != 0 && memq[0].due <= cyc) begin
                hit = 1'b1;
            end else begin
                step();
            end
        end
        check_eq("full_reached", 32'(hit), 32'd1);
        instruction_ready = 1'b1;
        redirect_to(32'h0000_0200);
        check_eq("full_redir_valid", 32'(instruction_valid), 32'd0);
        p0  = pops;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            step();
            if (pops != p0) hit = 1'b1;
        end
        check_eq("full_first_pc", last_pop_pc, 32'h0000_0200);

        // Address wrap at the top of the address space.
        wrap_seen = 1'b0;
        redirect_to(32'hFFFF_FFF8);
        for (int c = 0; c < 10; c++) step();
        check_eq("wrap_seen", 32'(wrap_seen), 32'd1);

        // Reset mid-stream, then restart from RESET_PC.
        do_reset();
        step();
        check_eq("rst2_boot_noreq", 32'(s_req), 32'd0);
        step();
        check_eq("rst2_req", 32'(s_req), 32'd1);
        check_eq("rst2_addr", s_addr, RESET_PC);
        for (int c = 0; c < 8; c++) step();

        check_eq("extra_pops", 32'(extra_pops), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
